out_signature_monitor: RTL and testbench
========================================

// Module: out_signature_monitor
// PURPOSE
//  Response-side companion to the fuzz stimulus driver. Sits on the DUT out_flat bus and compresses
//  one sampled output word per clock into a SIG_W-bit MISR signature over a programmed sample window.
//  Cross-simulator runs then compare one signature (and sample count), not full CYCLE/OUT trace logs.
// PARAMETERS
//  OUT_W        330            width of monitored out_flat bus
//  SIG_W        32             signature / fold width
//  POLY         32'h04C11DB7   MISR feedback polynomial (lower SIG_W bits used)
//  SEED         32'hFFFFFFFF   signature value loaded on reset and on accepted start
//  SKIP_CYCLES  2              cycles discarded after start before sampling (reset settle)
// PORTS
//  clk           in   1      clock, all state on posedge
//  rst_n         in   1      asynchronous active-low reset
//  out_flat      in   OUT_W  DUT output bus being monitored
//  start         in   1      1-cycle request to begin a capture window
//  num_cycles    in   32     samples to accumulate; latched when start accepted
//  expected_sig  in   SIG_W  golden signature for match flag
//  busy          out  1      high in SKIP or RUN
//  done          out  1      high in DONE; holds until next accepted start
//  signature     out  SIG_W  current MISR value
//  sample_count  out  32     samples accumulated since last accepted start
//  match         out  1      done && (signature == expected_sig), combinational
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, signature=SEED, sample_count=0, busy=0, done=0, skip ctr=0.
//  States: IDLE -> SKIP -> RUN -> DONE; DONE -> SKIP/RUN on start.
//  - start accepted only in IDLE or DONE; ignored in SKIP/RUN (no restart, no error).
//  - On accept: latch num_cycles, signature<=SEED, sample_count<=0, done<=0.
//    Next state SKIP if SKIP_CYCLES>0, else RUN; if latched num_cycles==0, go straight to DONE.
//  - SKIP: count SKIP_CYCLES posedges, no sampling; then RUN.
//  - RUN: every posedge samples out_flat:
//      fold = XOR of SIG_W-bit chunks of out_flat (chunk k = bits [k*SIG_W +: SIG_W]); last partial
//      chunk zero-extended (OUT_W=330 -> 11 chunks, top chunk 10 bits).
//      signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ fold.
//      sample_count <= sample_count+1 (wraps mod 2^32, never saturates).
//      Sample that makes sample_count==num_cycles -> next state DONE.
//  - Latency: done rises on posedge after the last sample; signature is final at same edge.
//  - DONE: signature, sample_count frozen; done=1, busy=0.
//  - Start in same cycle as last RUN sample: ignored (still RUN); DONE entered normally.
//  - Reset mid-window: window aborted, no partial result kept; new start required.
//  - out_flat X/Z not filtered; bench must drive known values during RUN.
// TESTING
//  T1 SKIP_CYCLES=0, out_flat=0, num_cycles=1, start -> 1 cycle later done=1, signature=32'hFB3EE249,
//     sample_count=1.
//  T2 As T1 but out_flat bit0=1 -> signature=32'hFB3EE248; expected_sig=32'hFB3EE248 -> match=1.
//  T3 As T1 but out_flat bits 0 and 32 set (fold cancels) -> signature=32'hFB3EE249; bit 329 alone
//     set -> signature=32'hFB3EE249 ^ 32'h200.
//  T4 num_cycles=0, start -> done=1 next cycle, signature=32'hFFFFFFFF, sample_count=0, busy never 1.
//  T5 SKIP_CYCLES=2, num_cycles=5, pulse start again in RUN -> ignored; busy high exactly 7 cycles,
//     done after 7th edge, sample_count=5; restart from DONE reloads SEED and clears done.
//  T6 rst_n low mid-RUN (async, between edges) -> outputs immediately IDLE/SEED/0 values;
//     after release, a fresh T1 window reproduces 32'hFB3EE249.

Source files
------------

// File: rtl/out_signature_monitor.sv
`default_nettype none
// ============================================================================
// out_signature_monitor : folds a wide output bus into a MISR signature over a
// start-triggered sample window.                                   Rev 1.0
// ============================================================================
module out_signature_monitor #(
  parameter int              OUT_W       = 330,
  parameter int              SIG_W       = 32,
  parameter logic [SIG_W-1:0] POLY       = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED       = 32'hFFFFFFFF,
  parameter int              SKIP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] out_flat,
  input  logic             start,
  input  logic [31:0]      num_cycles,
  input  logic [SIG_W-1:0] expected_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [31:0]      sample_count,
  output logic             match
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SKIP = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [31:0]      r_num;
  logic [31:0]      r_skip_cnt;
  logic [SIG_W-1:0] w_fold;
  logic [SIG_W-1:0] w_next_sig;
  logic [31:0]      w_next_count;

  // Bit i lands in fold position i mod SIG_W; the partial top chunk is thereby zero-extended.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_fold[i % SIG_W] = w_fold[i % SIG_W] ^ out_flat[i];
    end
  end

  assign w_next_sig   = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ w_fold;
  assign w_next_count = sample_count + 32'd1;
  assign match        = done && (signature == expected_sig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_num        <= '0;
      r_skip_cnt   <= '0;
      signature    <= SEED;
      sample_count <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_num        <= num_cycles;
            r_skip_cnt   <= '0;
            signature    <= SEED;
            sample_count <= '0;
            if (num_cycles == 32'd0) begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else if (SKIP_CYCLES > 0) begin
              r_state <= S_SKIP;
              done    <= 1'b0;
              busy    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              done    <= 1'b0;
              busy    <= 1'b1;
            end
          end
        end
        S_SKIP: begin
          r_skip_cnt <= r_skip_cnt + 32'd1;
          if (r_skip_cnt == 32'(SKIP_CYCLES - 1)) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          signature    <= w_next_sig;
          sample_count <= w_next_count;
          if (w_next_count == r_num) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_signature_monitor.sv
`default_nettype none
// ============================================================================
// tb_out_signature_monitor : bench for out_signature_monitor, one instance with
// no settle cycles and one with two.                               Rev 1.0
// ============================================================================
module tb_out_signature_monitor;

  logic         clk;
  logic         rst_n;
  logic [329:0] out_flat;
  logic         start;
  logic [31:0]  num_cycles;
  logic [31:0]  expected_sig;
  logic         busy0, done0, match0, busy2, done2, match2;
  logic [31:0]  sig0, cnt0, sig2, cnt2;

  int checks = 0;
  int errors = 0;

  logic [329:0] vals [0:63];

  out_signature_monitor #(.SKIP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .out_flat(out_flat), .start(start),
    .num_cycles(num_cycles), .expected_sig(expected_sig),
    .busy(busy0), .done(done0), .signature(sig0), .sample_count(cnt0), .match(match0)
  );

  out_signature_monitor #(.SKIP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .out_flat(out_flat), .start(start),
    .num_cycles(num_cycles), .expected_sig(expected_sig),
    .busy(busy2), .done(done2), .signature(sig2), .sample_count(cnt2), .match(match2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: word-at-a-time chunk XOR, then one CRC-style shift per sample.
  function automatic logic [31:0] ref_sig(input int lo, input int hi);
    logic [31:0]  s;
    logic [31:0]  f;
    logic [329:0] w;
    s = 32'hFFFFFFFF;
    for (int j = lo; j <= hi; j++) begin
      w = vals[j];
      f = 32'd0;
      for (int k = 0; k < 11; k++) f = f ^ 32'(w >> (k * 32));
      s = (s << 1) ^ (s[31] ? 32'h04C11DB7 : 32'd0) ^ f;
    end
    return s;
  endfunction

  function automatic logic [329:0] rand_word();
    logic [351:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[329:0];
  endfunction

  task automatic fill_vals(input logic [329:0] v, input bit rnd);
    for (int j = 0; j < 64; j++) vals[j] = rnd ? rand_word() : v;
  endtask

  // Runs one window of n samples on both instances; restart_at pulses a stray start mid-window.
  task automatic window(input int n, input int restart_at);
    int b0, b2, fd0, fd2;
    logic [31:0] e0, e2;
    b0 = 0; b2 = 0; fd0 = -1; fd2 = -1;
    @(negedge clk);
    num_cycles = 32'(n);
    start      = 1'b1;
    out_flat   = vals[0];
    for (int j = 1; j <= n + 4; j++) begin
      @(negedge clk);
      if (j == 1) begin
        chk("done0_cleared", {31'd0, done0}, 32'd0);
        chk("done2_cleared", {31'd0, done2}, 32'd0);
      end
      b0 += int'(busy0);
      b2 += int'(busy2);
      if (done0 && fd0 < 0) fd0 = j - 1;
      if (done2 && fd2 < 0) fd2 = j - 1;
      start      = (j == restart_at);
      num_cycles = $urandom_range(1, 3);
      out_flat   = vals[j];
    end
    start = 1'b0;
    e0 = ref_sig(1, n);
    e2 = ref_sig(3, n + 2);
    chk("sig0", sig0, e0);
    chk("cnt0", cnt0, 32'(n));
    chk("done0", {31'd0, done0}, 32'd1);
    chk("busy0_cycles", 32'(b0), 32'(n));
    chk("done0_edge", 32'(fd0), 32'(n));
    chk("match0", {31'd0, match0}, {31'd0, e0 == expected_sig});
    chk("sig2", sig2, e2);
    chk("cnt2", cnt2, 32'(n));
    chk("busy2_cycles", 32'(b2), 32'(n + 2));
    chk("done2_edge", 32'(fd2), 32'(n + 2));
    chk("match2", {31'd0, match2}, {31'd0, e2 == expected_sig});
  endtask

  initial begin
    int nb;
    rst_n        = 1'b0;
    start        = 1'b0;
    out_flat     = '0;
    num_cycles   = 32'd0;
    expected_sig = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_sig", sig0, 32'hFFFFFFFF);
    chk("rst_cnt", cnt0, 32'd0);
    chk("rst_busy_done", {30'd0, busy0, done0}, 32'd0);
    chk("rst_sig2", sig2, 32'hFFFFFFFF);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all-zero bus, one sample
    fill_vals('0, 1'b0);
    window(1, 0);
    chk("t1_sig", sig0, 32'hFB3EE249);

    // T2: bit 0 set, golden signature supplied
    expected_sig = 32'hFB3EE248;
    fill_vals(330'd1, 1'b0);
    window(1, 0);
    chk("t2_sig", sig0, 32'hFB3EE248);
    chk("t2_match", {31'd0, match0}, 32'd1);

    // T3: chunk fold cancellation and top partial chunk
    fill_vals((330'd1 << 32) | 330'd1, 1'b0);
    window(1, 0);
    chk("t3_cancel", sig0, 32'hFB3EE249);
    fill_vals(330'd1 << 329, 1'b0);
    window(1, 0);
    chk("t3_bit329", sig0, 32'hFB3EE249 ^ 32'h200);

    // T4: zero-length window
    nb = 0;
    @(negedge clk);
    num_cycles = 32'd0;
    start      = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      start = 1'b0;
      nb += int'(busy0) + int'(busy2);
      if (j == 1) begin
        chk("t4_done", {30'd0, done0, done2}, 32'd3);
        chk("t4_sig", sig0, 32'hFFFFFFFF);
        chk("t4_cnt", cnt2, 32'd0);
      end
    end
    chk("t4_busy_never", 32'(nb), 32'd0);

    // T5: random data, stray start inside RUN, then restart from DONE
    fill_vals('0, 1'b1);
    window(5, 4);
    fill_vals('0, 1'b1);
    window(5, 5);
    for (int r = 0; r < 4; r++) begin
      fill_vals('0, 1'b1);
      expected_sig = ref_sig(3, 0);
      window(int'($urandom_range(2, 20)), int'($urandom_range(1, 2)));
    end
    fill_vals('0, 1'b1);
    expected_sig = ref_sig(3, 8);
    window(6, 0);

    // T6: asynchronous reset mid-window
    fill_vals('0, 1'b1);
    @(negedge clk);
    num_cycles = 32'd10;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_sig0", sig0, 32'hFFFFFFFF);
    chk("t6_cnt0", cnt0, 32'd0);
    chk("t6_flags0", {30'd0, busy0, done0}, 32'd0);
    chk("t6_flags2", {30'd0, busy2, done2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stays_idle", {28'd0, busy0, done0, busy2, done2}, 32'd0);
    fill_vals('0, 1'b0);
    window(1, 0);
    chk("t6_fresh_sig", sig0, 32'hFB3EE249);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
